ntp_pkt_builder: RTL and testbench

Parametrised successor to the fixed 48-byte NTP reply maker. It builds a complete NTP packet (client request or server reply) from a snapshot of timestamp and root fields taken at trigger time. It streams the packet byte-by-byte into the UDP transmit buffer using a ready/valid write handshake with backpressure. It sits between the NTP timestamp logic and the UDP/Ethernet TX packet RAM.

---
 rtl/ntp_pkg.sv | 24 ++
 rtl/ntp_byte_sel.sv | 57 +++++
 rtl/ntp_pkt_builder.sv | 166 ++++++++++++++++
 tb/tb_ntp_pkt_builder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntp_pkg.sv
// Shared constants, byte offsets and FSM state type for the NTP packet builder.
package ntp_pkg;

   localparam logic [2:0] NTP_VN      = 3'd4;
   localparam logic [2:0] MODE_CLIENT = 3'd3;
   localparam logic [2:0] MODE_SERVER = 3'd4;

   localparam int OFS_ROOT_DLY = 4;
   localparam int OFS_ROOT_DSP = 8;
   localparam int OFS_REFID    = 12;
   localparam int OFS_REF_TS   = 16;
   localparam int OFS_ORIG_TS  = 24;
   localparam int OFS_RX_TS    = 32;
   localparam int OFS_TX_TS    = 40;
   localparam int NTP_HDR_LEN  = 48;

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   // Byte k (0 = most significant) of an nbytes-wide field held right-aligned in f.
   function automatic logic [7:0] pick_byte(input logic [63:0] f, input int nbytes, input int k);
      return 8'(f >> (8 * (nbytes - 1 - k)));
   endfunction

endpackage

// File: rtl/ntp_byte_sel.sv
// Combinational byte mux: returns packet byte i_idx from the snapshot fields,
// zeroing the ref/orig/rx timestamps for client requests and padding past the header.
module ntp_byte_sel
   import ntp_pkg::*;
#(
   parameter int          ADDR_W    = 11,
   parameter logic [7:0]  STRATUM   = 8'h02,
   parameter logic [7:0]  POLL      = 8'h04,
   parameter logic [7:0]  PRECISION = 8'hEC,
   parameter logic [31:0] REF_ID    = 32'h0000_0000
) (
   input  logic [1:0]        i_leap,
   input  logic [2:0]        i_mode,
   input  logic [31:0]       i_root_delay,
   input  logic [31:0]       i_root_disper,
   input  logic [63:0]       i_ref_ts,
   input  logic [63:0]       i_orig_ts,
   input  logic [63:0]       i_rx_ts,
   input  logic [63:0]       i_tx_ts,
   input  logic [ADDR_W-1:0] i_idx,
   output logic [7:0]        o_byte
);

   int   w_idx;
   logic w_client;

   assign w_idx    = int'(i_idx);
   assign w_client = (i_mode == MODE_CLIENT);

   // Walk the header layout field by field; anything beyond the header is padding.
   always_comb begin
      o_byte = 8'h00;
      if (w_idx == 0)
         o_byte = {i_leap, NTP_VN, i_mode};
      else if (w_idx == 1)
         o_byte = STRATUM;
      else if (w_idx == 2)
         o_byte = POLL;
      else if (w_idx == 3)
         o_byte = PRECISION;
      else if (w_idx < OFS_ROOT_DSP)
         o_byte = pick_byte({32'h0, i_root_delay}, 4, w_idx - OFS_ROOT_DLY);
      else if (w_idx < OFS_REFID)
         o_byte = pick_byte({32'h0, i_root_disper}, 4, w_idx - OFS_ROOT_DSP);
      else if (w_idx < OFS_REF_TS)
         o_byte = pick_byte({32'h0, REF_ID}, 4, w_idx - OFS_REFID);
      else if (w_idx < OFS_ORIG_TS)
         o_byte = w_client ? 8'h00 : pick_byte(i_ref_ts, 8, w_idx - OFS_REF_TS);
      else if (w_idx < OFS_RX_TS)
         o_byte = w_client ? 8'h00 : pick_byte(i_orig_ts, 8, w_idx - OFS_ORIG_TS);
      else if (w_idx < OFS_TX_TS)
         o_byte = w_client ? 8'h00 : pick_byte(i_rx_ts, 8, w_idx - OFS_RX_TS);
      else if (w_idx < NTP_HDR_LEN)
         o_byte = pick_byte(i_tx_ts, 8, w_idx - OFS_TX_TS);
   end

endmodule

// File: rtl/ntp_pkt_builder.sv
// NTP packet builder: snapshots the timestamp/root fields on a trigger and
// streams the packet byte by byte into the UDP TX buffer with backpressure.
module ntp_pkt_builder
   import ntp_pkg::*;
#(
   parameter int          ADDR_W    = 11,
   parameter int          PKT_LEN   = 48,
   parameter logic [7:0]  STRATUM   = 8'h02,
   parameter logic [7:0]  POLL      = 8'h04,
   parameter logic [7:0]  PRECISION = 8'hEC,
   parameter logic [31:0] REF_ID    = 32'h0000_0000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_trig,
   input  logic [2:0]        i_mode,
   input  logic [1:0]        i_leap,
   input  logic [31:0]       i_root_delay,
   input  logic [31:0]       i_root_disper,
   input  logic [63:0]       i_ref_ts,
   input  logic [63:0]       i_orig_ts,
   input  logic [63:0]       i_rx_ts,
   input  logic [63:0]       i_tx_ts,
   input  logic              i_wr_ready,
   output logic              o_wr_req,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [7:0]        o_wr_data,
   output logic [ADDR_W-1:0] o_send_num,
   output logic              o_busy,
   output logic              o_cmd_end,
   output logic [7:0]        o_drop_cnt,
   output logic [63:0]       o_last_tx_ts
);

   generate
      if (PKT_LEN < NTP_HDR_LEN || PKT_LEN > (1 << ADDR_W)) begin : g_bad_len
         $error("ntp_pkt_builder: PKT_LEN must lie in 48..2**ADDR_W");
      end
   endgenerate

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PKT_LEN - 1);
   localparam logic [ADDR_W-1:0] SEND_NUM = ADDR_W'(PKT_LEN);

   state_t            r_state, w_next;
   logic              r_arm;
   logic [ADDR_W-1:0] r_idx;
   logic [7:0]        r_data;
   logic [7:0]        r_drop;
   logic [2:0]        r_mode;
   logic [1:0]        r_leap;
   logic [31:0]       r_root_delay, r_root_disper;
   logic [63:0]       r_ref_ts, r_orig_ts, r_rx_ts, r_last_tx;

   logic              w_trig, w_xfer, w_last;
   logic [ADDR_W-1:0] w_nxt_idx, w_sel_idx;
   logic [1:0]        w_sel_leap;
   logic [2:0]        w_sel_mode;
   logic [7:0]        w_sel_byte;

   // r_arm stays low for the first cycle after reset release so a trigger
   // coincident with release is ignored.
   assign w_trig    = i_trig && r_arm;
   assign w_xfer    = (r_state == SEND) && i_wr_ready;
   assign w_last    = w_xfer && (r_idx == LAST_IDX);
   assign w_nxt_idx = r_idx + ADDR_W'(1);

   // The selector looks one byte ahead so o_wr_data can be registered alongside
   // the index. At capture time the snapshot is not loaded yet, so byte 0 takes
   // leap/mode straight from the inputs (byte 0 depends on nothing else).
   assign w_sel_idx  = (r_state == IDLE) ? '0 : w_nxt_idx;
   assign w_sel_leap = (r_state == IDLE) ? i_leap : r_leap;
   assign w_sel_mode = (r_state == IDLE) ? i_mode : r_mode;

   ntp_byte_sel #(
      .ADDR_W    (ADDR_W),
      .STRATUM   (STRATUM),
      .POLL      (POLL),
      .PRECISION (PRECISION),
      .REF_ID    (REF_ID)
   ) u_byte_sel (
      .i_leap        (w_sel_leap),
      .i_mode        (w_sel_mode),
      .i_root_delay  (r_root_delay),
      .i_root_disper (r_root_disper),
      .i_ref_ts      (r_ref_ts),
      .i_orig_ts     (r_orig_ts),
      .i_rx_ts       (r_rx_ts),
      .i_tx_ts       (r_last_tx),
      .i_idx         (w_sel_idx),
      .o_byte        (w_sel_byte)
   );

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // FSM next-state: IDLE -> SEND on trigger, SEND -> DONE on last byte, DONE lasts one cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_trig) w_next = SEND;
         SEND:    if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Snapshot capture, byte index and registered write data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_arm         <= 1'b0;
         r_idx         <= '0;
         r_data        <= 8'h00;
         r_mode        <= 3'd0;
         r_leap        <= 2'd0;
         r_root_delay  <= 32'h0;
         r_root_disper <= 32'h0;
         r_ref_ts      <= 64'h0;
         r_orig_ts     <= 64'h0;
         r_rx_ts       <= 64'h0;
         r_last_tx     <= 64'h0;
      end else begin
         r_arm <= 1'b1;
         if (r_state == IDLE && w_trig) begin
            r_mode        <= i_mode;
            r_leap        <= i_leap;
            r_root_delay  <= i_root_delay;
            r_root_disper <= i_root_disper;
            r_ref_ts      <= i_ref_ts;
            r_orig_ts     <= i_orig_ts;
            r_rx_ts       <= i_rx_ts;
            r_last_tx     <= i_tx_ts;
            r_idx         <= '0;
            r_data        <= w_sel_byte;
         end else if (w_xfer) begin
            if (w_last) begin
               r_idx  <= '0;
               r_data <= 8'h00;
            end else begin
               r_idx  <= w_nxt_idx;
               r_data <= w_sel_byte;
            end
         end
      end
   end

   // Count triggers that arrive while a packet is in progress, saturating at 0xFF.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_drop <= 8'h00;
      else if (w_trig && r_state != IDLE && r_drop != 8'hFF)
         r_drop <= r_drop + 8'h01;
   end

   assign o_wr_req     = (r_state == SEND);
   assign o_busy       = (r_state != IDLE);
   assign o_cmd_end    = (r_state == DONE);
   assign o_wr_addr    = r_idx;
   assign o_wr_data    = r_data;
   assign o_send_num   = SEND_NUM;
   assign o_drop_cnt   = r_drop;
   assign o_last_tx_ts = r_last_tx;

endmodule

// File: tb/tb_ntp_pkt_builder.sv
// Scoreboard bench for ntp_pkt_builder: two instances (48- and 64-byte packets)
// share stimulus; per-instance monitors pop expected bytes from queues filled by
// a byte-list reference model at trigger time.
module tb_ntp_pkt_builder;

   typedef logic [7:0] bq_t[$];
   typedef struct {int addr; logic [7:0] data;} exp_t;
   typedef struct packed {
      logic [2:0]  mode;
      logic [1:0]  leap;
      logic [31:0] rd, rdsp;
      logic [63:0] ref_ts, orig, rx, tx;
   } pkt_t;

   logic        clk = 1'b0, rst_n = 1'b0, trig = 1'b0, rdy = 1'b0;
   logic [2:0]  mode;
   logic [1:0]  leap;
   logic [31:0] rd, rdsp;
   logic [63:0] ref_ts, orig, rx, tx;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, trig_cyc = -1000, rdy_mode = 0, exp_drop = 0;
   bit full_speed = 1'b0;

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc = cyc + 1; end

   // Ready driver: 0 = always ready, 1 = never ready, otherwise random.
   initial forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0)      rdy = 1'b1;
      else if (rdy_mode == 1) rdy = 1'b0;
      else                    rdy = 1'($urandom_range(0, 1));
   end

   // Reference model: the packet as a plain list of bytes.
   function automatic bq_t model(input int plen, input logic [31:0] rid, input pkt_t p);
      bq_t b;
      logic [63:0] ts[4];
      ts = '{p.ref_ts, p.orig, p.rx, p.tx};
      b.push_back({p.leap, 3'd4, p.mode});
      b.push_back(8'h02); b.push_back(8'h04); b.push_back(8'hEC);
      for (int i = 0; i < 4; i++) b.push_back(8'(p.rd   >> (24 - 8 * i)));
      for (int i = 0; i < 4; i++) b.push_back(8'(p.rdsp >> (24 - 8 * i)));
      for (int i = 0; i < 4; i++) b.push_back(8'(rid    >> (24 - 8 * i)));
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < 8; i++)
            b.push_back((p.mode == 3'd3 && k < 3) ? 8'h00 : 8'(ts[k] >> (56 - 8 * i)));
      while (b.size() < plen) b.push_back(8'h00);
      return b;
   endfunction

   genvar n;
   generate
      for (n = 0; n < 2; n++) begin : g_inst
         localparam int          PL  = (n == 0) ? 48 : 64;
         localparam logic [31:0] RID = (n == 0) ? 32'h0 : 32'hDEAD_BEEF;
         logic        req, busy, cend;
         logic [10:0] addr, snum;
         logic [7:0]  data, drop;
         logic [63:0] ltx;
         exp_t q[$];

         ntp_pkt_builder #(.ADDR_W(11), .PKT_LEN(PL), .REF_ID(RID)) dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_mode(mode), .i_leap(leap),
            .i_root_delay(rd), .i_root_disper(rdsp), .i_ref_ts(ref_ts), .i_orig_ts(orig),
            .i_rx_ts(rx), .i_tx_ts(tx), .i_wr_ready(rdy), .o_wr_req(req), .o_wr_addr(addr),
            .o_wr_data(data), .o_send_num(snum), .o_busy(busy), .o_cmd_end(cend),
            .o_drop_cnt(drop), .o_last_tx_ts(ltx)
         );

         // Monitor: pops on each accepted byte, checks stall stability and cmd_end timing.
         initial begin : mon
            exp_t        e;
            bit          p_last, p_stall;
            logic [10:0] p_addr;
            logic [7:0]  p_data;
            p_last = 1'b0; p_stall = 1'b0; p_addr = '0; p_data = '0;
            forever begin
               @(negedge clk);
               if (!rst_n) begin
                  p_last = 1'b0; p_stall = 1'b0;
               end else begin
                  if (p_stall && req) begin
                     n_cmp++;
                     if (addr !== p_addr || data !== p_data) begin
                        n_bad++;
                        $display("FAIL stall_hold[%0d] got %0d/%h need %0d/%h", PL, addr, data, p_addr, p_data);
                     end
                  end
                  if (cend || p_last) begin
                     n_cmp++;
                     if (cend !== p_last) begin
                        n_bad++;
                        $display("FAIL cmd_end[%0d] got %b need %b at cyc %0d", PL, cend, p_last, cyc);
                     end else if (full_speed && cyc != trig_cyc + PL + 1) begin
                        n_bad++;
                        $display("FAIL cmd_end_lat[%0d] got cyc %0d need %0d", PL, cyc, trig_cyc + PL + 1);
                     end
                  end
                  p_last = 1'b0;
                  if (req && rdy) begin
                     n_cmp++;
                     if (q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_byte[%0d] got addr %0d data %h need none", PL, addr, data);
                     end else begin
                        e = q.pop_front();
                        if (addr !== e.addr[10:0] || data !== e.data) begin
                           n_bad++;
                           $display("FAIL byte[%0d] got %0d/%h need %0d/%h", PL, addr, data, e.addr, e.data);
                        end else if (full_speed && cyc != trig_cyc + 1 + e.addr) begin
                           n_bad++;
                           $display("FAIL byte_lat[%0d] addr %0d got cyc %0d need %0d", PL, e.addr, cyc, trig_cyc + 1 + e.addr);
                        end
                        p_last = (e.addr == PL - 1);
                     end
                  end
                  p_stall = req && !rdy;
                  p_addr  = addr;
                  p_data  = data;
               end
            end
         end
      end
   endgenerate

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got %h need %h", nm, act, exp);
      end
   endtask

   function automatic pkt_t rand_pkt();
      pkt_t p;
      p.mode = 3'($urandom); p.leap = 2'($urandom);
      p.rd = $urandom; p.rdsp = $urandom;
      p.ref_ts = {$urandom, $urandom}; p.orig = {$urandom, $urandom};
      p.rx = {$urandom, $urandom};     p.tx = {$urandom, $urandom};
      return p;
   endfunction

   task automatic apply(input pkt_t p);
      mode = p.mode; leap = p.leap; rd = p.rd; rdsp = p.rdsp;
      ref_ts = p.ref_ts; orig = p.orig; rx = p.rx; tx = p.tx;
   endtask

   task automatic push_exp(input pkt_t p);
      bq_t b;
      b = model(48, 32'h0, p);
      for (int i = 0; i < b.size(); i++) g_inst[0].q.push_back('{addr: i, data: b[i]});
      b = model(64, 32'hDEAD_BEEF, p);
      for (int i = 0; i < b.size(); i++) g_inst[1].q.push_back('{addr: i, data: b[i]});
   endtask

   // Trigger for 1+extra cycles (extra cycles land while busy), then scramble inputs.
   task automatic start_pkt(input pkt_t p, input bit fs, input int extra);
      apply(p);
      full_speed = fs;
      push_exp(p);
      trig = 1'b1;
      trig_cyc = cyc;
      tick(1);
      for (int i = 0; i < extra; i++) begin apply(rand_pkt()); tick(1); end
      trig = 1'b0;
      apply(rand_pkt());
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((g_inst[0].busy || g_inst[1].busy) && k < 2000) begin tick(1); k++; end
      n_cmp++;
      if (k >= 2000) begin n_bad++; $display("FAIL wait_idle got busy need idle within 2000 cycles"); end
      tick(1);
   endtask

   task automatic pulse_at(input int c);
      tick(c - cyc);
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
   endtask

   task automatic check_zero();
      check("rst_req48",  g_inst[0].req,  0); check("rst_req64",  g_inst[1].req,  0);
      check("rst_busy48", g_inst[0].busy, 0); check("rst_busy64", g_inst[1].busy, 0);
      check("rst_end48",  g_inst[0].cend, 0); check("rst_end64",  g_inst[1].cend, 0);
      check("rst_addr48", g_inst[0].addr, 0); check("rst_addr64", g_inst[1].addr, 0);
      check("rst_data48", g_inst[0].data, 0); check("rst_data64", g_inst[1].data, 0);
      check("rst_drop48", g_inst[0].drop, 0); check("rst_drop64", g_inst[1].drop, 0);
      check("rst_ltx48",  g_inst[0].ltx,  0); check("rst_ltx64",  g_inst[1].ltx,  0);
      check("rst_snum48", g_inst[0].snum, 48); check("rst_snum64", g_inst[1].snum, 64);
   endtask

   task automatic check_drops(input string nm);
      check({nm, "_drop48"}, g_inst[0].drop, 64'(exp_drop));
      check({nm, "_drop64"}, g_inst[1].drop, 64'(exp_drop));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog got no finish need finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      pkt_t p;
      int k;
      apply(rand_pkt());
      tick(3);
      check_zero();
      rst_n = 1'b1;
      tick(3);

      // Server reply with fixed fields, full speed.
      p = rand_pkt();
      p.mode = 3'd4; p.leap = 2'd0; p.rd = 32'h0000_1234; p.tx = 64'hE1B2_0000_8000_0000;
      start_pkt(p, 1'b1, 0);
      tick(1);
      check("last_tx48", g_inst[0].ltx, p.tx);
      check("last_tx64", g_inst[1].ltx, p.tx);
      wait_idle();

      // Client request: ref/orig/rx zeroed.
      p = rand_pkt();
      p.mode = 3'd3;
      start_pkt(p, 1'b1, 0);
      wait_idle();

      // Drops: three during SEND, one in the 48-byte instance's DONE cycle.
      p = rand_pkt();
      start_pkt(p, 1'b1, 0);
      pulse_at(trig_cyc + 3);
      pulse_at(trig_cyc + 10);
      pulse_at(trig_cyc + 20);
      pulse_at(trig_cyc + 49);
      exp_drop += 4;
      wait_idle();
      check_drops("four");

      // Random packets under random backpressure.
      rdy_mode = 2;
      for (int i = 0; i < 6; i++) begin
         start_pkt(rand_pkt(), 1'b0, 0);
         wait_idle();
         tick($urandom_range(0, 3));
      end
      check_drops("random");

      // Saturation: hold trigger 300 extra cycles while stalled.
      rdy_mode = 1;
      tick(1);
      start_pkt(rand_pkt(), 1'b0, 300);
      exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
      rdy_mode = 2;
      wait_idle();
      check_drops("sat");

      // Reset mid-packet at byte 20, trigger coinciding with release, then restart.
      rdy_mode = 0;
      tick(1);
      start_pkt(rand_pkt(), 1'b1, 0);
      k = 0;
      while (g_inst[0].addr != 11'd20 && k < 100) begin tick(1); k++; end
      check("reach_byte20", 64'(k < 100), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero();
      g_inst[0].q.delete();
      g_inst[1].q.delete();
      exp_drop = 0;
      tick(2);
      rst_n = 1'b1;
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
      tick(1);
      check("rel_trig_busy48", g_inst[0].busy, 0);
      check("rel_trig_busy64", g_inst[1].busy, 0);
      tick(2);
      start_pkt(rand_pkt(), 1'b1, 0);
      wait_idle();
      check_drops("post_rst");

      tick(3);
      check("q_empty48", 64'(g_inst[0].q.size()), 0);
      check("q_empty64", 64'(g_inst[1].q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
